// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and store codes for the IF/MEM SRAM port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_IF = 2'd1,
        ST_WAIT_DM = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_t;

    // Unshifted store codes as produced by the decoder
    localparam logic [3:0] SB_EN = 4'b0001;
    localparam logic [3:0] SH_EN = 4'b0011;
    localparam logic [3:0] SW_EN = 4'b1111;

endpackage

// File: rtl/dm_store_align.sv
// rtl/dm_store_align.sv - shifts store byte-enables/data into lane position and flags misaligned stores
module dm_store_align
    import mem_arb_pkg::*;
(
    input  logic [3:0]  dm_w_en,
    input  logic [1:0]  off,
    input  logic [31:0] dm_wdata,
    output logic [3:0]  mem_w_en,
    output logic [31:0] mem_wdata,
    output logic        misaligned
);

    assign mem_w_en  = dm_w_en << off;
    assign mem_wdata = dm_wdata << {off, 3'b000};

    // Loads (0000) and byte stores can never straddle a word
    always_comb begin
        misaligned = 1'b0;
        case (dm_w_en)
            SB_EN:   misaligned = 1'b0;
            SH_EN:   misaligned = (off == 2'd3);
            SW_EN:   misaligned = (off != 2'd0);
            default: misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sequencer for a fixed-latency SRAM shared by fetch and data stages
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int MEM_AW  = 14,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [3:0]        dm_w_en,
    input  logic [31:0]       dm_wdata,
    output logic              dm_done,
    output logic [31:0]       dm_rdata,
    output logic              dm_misaligned,
    output logic              stall_if,
    output logic              stall_dm,
    output logic              mem_cs,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [3:0]        mem_w_en,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    grant_t     r_last_grant;
    grant_t     w_last_grant_nxt;
    logic       r_dm_store;
    logic       w_dm_store_nxt;
    logic       r_dm_misal;
    logic       w_dm_misal_nxt;

    logic        w_if_done;
    logic        w_dm_done;
    logic        w_arb_point;
    logic        w_if_elig;
    logic        w_dm_elig;
    logic        w_gnt_if;
    logic        w_gnt_dm;
    logic        w_dm_issue;
    logic [3:0]  w_al_w_en;
    logic [31:0] w_al_wdata;
    logic        w_al_misal;
    logic        w_unused_addr;

    dm_store_align u_align (
        .dm_w_en    (dm_w_en),
        .off        (dm_addr[1:0]),
        .dm_wdata   (dm_wdata),
        .mem_w_en   (w_al_w_en),
        .mem_wdata  (w_al_wdata),
        .misaligned (w_al_misal)
    );

    // Responses are suppressed while rst is high so an in-flight access never completes
    assign w_if_done = ~rst & (r_state == ST_WAIT_IF) & (r_cnt == 3'd0);
    assign w_dm_done = ~rst & (r_state == ST_WAIT_DM) & (r_cnt == 3'd0);

    // The final wait cycle doubles as an arbitration point for back-to-back issue
    assign w_arb_point = (r_state == ST_IDLE) | w_if_done | w_dm_done;
    assign w_if_elig   = if_req & ~w_if_done;
    assign w_dm_elig   = dm_req & ~w_dm_done;

    assign w_gnt_if   = ~rst & w_arb_point & w_if_elig & (~w_dm_elig | (r_last_grant == GNT_DM));
    assign w_gnt_dm   = ~rst & w_arb_point & w_dm_elig & (~w_if_elig | (r_last_grant == GNT_IF));
    assign w_dm_issue = w_gnt_dm & ~w_al_misal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 3'd0;
            r_last_grant <= GNT_DM;
            r_dm_store   <= 1'b0;
            r_dm_misal   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_dm_store   <= w_dm_store_nxt;
            r_dm_misal   <= w_dm_misal_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_last_grant_nxt = r_last_grant;
        w_dm_store_nxt   = r_dm_store;
        w_dm_misal_nxt   = r_dm_misal;

        case (r_state)
            ST_WAIT_IF, ST_WAIT_DM: begin
                if (r_cnt != 3'd0) begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_gnt_if) begin
            w_state_nxt      = ST_WAIT_IF;
            w_cnt_nxt        = CNT_LOAD;
            w_last_grant_nxt = GNT_IF;
        end else if (w_gnt_dm) begin
            // A rejected store skips the SRAM and reports on the very next cycle
            w_state_nxt      = ST_WAIT_DM;
            w_cnt_nxt        = w_al_misal ? 3'd0 : CNT_LOAD;
            w_last_grant_nxt = GNT_DM;
            w_dm_store_nxt   = (dm_w_en != 4'b0000);
            w_dm_misal_nxt   = w_al_misal;
        end
    end

    assign mem_cs    = w_gnt_if | w_dm_issue;
    assign mem_addr  = w_gnt_if   ? if_addr[MEM_AW+1:2] :
                       w_dm_issue ? dm_addr[MEM_AW+1:2] : '0;
    assign mem_w_en  = w_dm_issue ? w_al_w_en  : 4'b0000;
    assign mem_wdata = w_dm_issue ? w_al_wdata : 32'd0;

    assign if_done       = w_if_done;
    assign if_rdata      = w_if_done ? mem_rdata : 32'd0;
    assign dm_done       = w_dm_done;
    assign dm_rdata      = (w_dm_done & ~r_dm_store) ? mem_rdata : 32'd0;
    assign dm_misaligned = w_dm_done & r_dm_misal;

    assign stall_if = ~rst & if_req & ~w_if_done;
    assign stall_dm = ~rst & dm_req & ~w_dm_done;

    assign w_unused_addr = ^{if_addr[ADDR_W-1:MEM_AW+2], if_addr[1:0], dm_addr[ADDR_W-1:MEM_AW+2]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a fixed-latency SRAM model
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [3:0]  dm_w_en;
    logic        if_done, dm_done, dm_misaligned, stall_if, stall_dm, mem_cs;
    logic [31:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
    logic [13:0] mem_addr;
    logic [3:0]  mem_w_en;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .MEM_AW(14), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_w_en(dm_w_en), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_misaligned(dm_misaligned),
        .stall_if(stall_if), .stall_dm(stall_dm),
        .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_w_en(mem_w_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word_of(input logic [13:0] a);
        return {8'h5A, 10'h000, a};
    endfunction

    // SRAM model: data for an access issued in cycle t appears during cycle t+LAT
    logic [13:0] sr_addr [LAT];
    logic        sr_v    [LAT];
    always @(posedge clk) begin
        sr_v[0]    <= rst ? 1'b0 : mem_cs;
        sr_addr[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) begin
            sr_v[i]    <= rst ? 1'b0 : sr_v[i-1];
            sr_addr[i] <= sr_addr[i-1];
        end
    end
    assign mem_rdata = sr_v[LAT-1] ? word_of(sr_addr[LAT-1]) : 32'hBAD0_BAD0;

    typedef struct {
        int          c;
        logic [13:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
        bit          chk_wdata;
    } iss_t;
    typedef struct {
        int          c;
        bit          is_dm;
        logic [31:0] rdata;
        bit          mis;
    } dn_t;

    iss_t iss_q[$];
    dn_t  dn_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_iss(input int c, input logic [13:0] a, input logic [3:0] w,
                            input logic [31:0] d, input bit chk);
        iss_t e;
        e.c = c; e.addr = a; e.wen = w; e.wdata = d; e.chk_wdata = chk;
        iss_q.push_back(e);
    endtask

    task automatic push_dn(input int c, input bit is_dm, input logic [31:0] r, input bit mis);
        dn_t e;
        e.c = c; e.is_dm = is_dm; e.rdata = r; e.mis = mis;
        dn_q.push_back(e);
    endtask

    // Monitor: every SRAM issue and every done pulse must match the next scoreboard entry
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_cs) begin
                check("issue_expected", 32'(iss_q.size() > 0), 32'd1);
                if (iss_q.size() > 0) begin
                    iss_t e;
                    e = iss_q.pop_front();
                    if (e.c >= 0) check("issue_cycle", cyc, e.c);
                    check("mem_addr", 32'(mem_addr), 32'(e.addr));
                    check("mem_w_en", 32'(mem_w_en), 32'(e.wen));
                    if (e.chk_wdata) check("mem_wdata", mem_wdata, e.wdata);
                end
            end
            if (if_done || dm_done) begin
                check("done_expected", 32'(dn_q.size() > 0), 32'd1);
                check("done_exclusive", 32'(if_done & dm_done), 32'd0);
                if (dn_q.size() > 0) begin
                    dn_t e;
                    e = dn_q.pop_front();
                    if (e.c >= 0) check("done_cycle", cyc, e.c);
                    check("done_is_dm", 32'(dm_done), 32'(e.is_dm));
                    if (dm_done) begin
                        check("dm_rdata", dm_rdata, e.rdata);
                        check("dm_misaligned", 32'(dm_misaligned), 32'(e.mis));
                    end else begin
                        check("if_rdata", if_rdata, e.rdata);
                    end
                end
            end
        end
    end

    task automatic if_run(input logic [31:0] a);
        bit got = 0;
        if_req  = 1'b1;
        if_addr = a;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (if_done) got = 1;
        end
        if (!got) check("if_done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic dm_run(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        bit got = 0;
        dm_req   = 1'b1;
        dm_addr  = a;
        dm_w_en  = w;
        dm_wdata = d;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (dm_done) begin
                got = 1;
                check("stall_dm_at_done", 32'(stall_dm), 32'd0);
            end else begin
                check("stall_dm_waiting", 32'(stall_dm), 32'd1);
            end
        end
        if (!got) check("dm_done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_cs"}, 32'(mem_cs), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_w_en"}, 32'(mem_w_en), 32'd0);
        check({tag, "_if_done"}, 32'(if_done), 32'd0);
        check({tag, "_dm_done"}, 32'(dm_done), 32'd0);
        check({tag, "_dm_mis"}, 32'(dm_misaligned), 32'd0);
        check({tag, "_stall_if"}, 32'(stall_if), 32'd0);
        check({tag, "_stall_dm"}, 32'(stall_dm), 32'd0);
        check({tag, "_if_rdata"}, if_rdata, 32'd0);
        check({tag, "_dm_rdata"}, dm_rdata, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0;
        if_addr = '0; dm_addr = '0; dm_w_en = '0; dm_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;

        // IF-only stream; low address bits of the last fetch are ignored
        c = cyc;
        push_iss(c, 14'h040, 4'h0, 32'h0, 0);
        push_dn(c + 2, 0, word_of(14'h040), 0);
        push_iss(-1, 14'h041, 4'h0, 32'h0, 0);
        push_dn(-1, 0, word_of(14'h041), 0);
        push_iss(-1, 14'h042, 4'h0, 32'h0, 0);
        push_dn(-1, 0, word_of(14'h042), 0);
        if_run(32'h100); if_run(32'h104); if_run(32'h10B);
        if_req = 1'b0;

        // Store alignment and misaligned rejection
        c = cyc; push_iss(c, 14'h080, 4'b1000, 32'hAB00_0000, 1); push_dn(c + 2, 1, 32'h0, 0);
        dm_run(32'h203, 4'b0001, 32'h0000_00AB);
        c = cyc; push_dn(c + 1, 1, 32'h0, 1);
        dm_run(32'h003, 4'b0011, 32'h0000_1234);
        c = cyc; push_iss(c, 14'h001, 4'b1111, 32'hDEAD_BEEF, 1); push_dn(c + 2, 1, 32'h0, 0);
        dm_run(32'h004, 4'b1111, 32'hDEAD_BEEF);
        c = cyc; push_iss(c, 14'h008, 4'b1100, 32'h5678_0000, 1); push_dn(c + 2, 1, 32'h0, 0);
        dm_run(32'h022, 4'b0011, 32'h0000_5678);
        c = cyc; push_dn(c + 1, 1, 32'h0, 1);
        dm_run(32'h006, 4'b1111, 32'h0102_0304);
        c = cyc; push_iss(c, 14'h081, 4'b0000, 32'h0, 0); push_dn(c + 2, 1, word_of(14'h081), 0);
        dm_run(32'h207, 4'b0000, 32'h0);
        dm_req = 1'b0;

        // After an IF grant a tie goes to DM
        push_iss(-1, 14'h140, 4'h0, 32'h0, 0); push_dn(-1, 0, word_of(14'h140), 0);
        if_run(32'h500);
        if_req = 1'b0;
        c = cyc;
        push_iss(c, 14'h180, 4'h0, 32'h0, 0);     push_dn(c + 2, 1, word_of(14'h180), 0);
        push_iss(c + 2, 14'h141, 4'h0, 32'h0, 0); push_dn(c + 4, 0, word_of(14'h141), 0);
        fork
            begin if_run(32'h504); if_req = 1'b0; end
            begin dm_run(32'h600, 4'b0000, 32'h0); dm_req = 1'b0; end
        join

        // Reset restores IF priority; then both held for 8 accesses alternate
        push_iss(-1, 14'h1C0, 4'h0, 32'h0, 0); push_dn(-1, 0, word_of(14'h1C0), 0);
        if_run(32'h700);
        if_req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            push_iss(c + 4*k, 14'h100 + 14'(k), 4'h0, 32'h0, 0);
            push_iss(c + 4*k + 2, 14'h0C0 + 14'(k), 4'h0, 32'h0, 0);
            push_dn(c + 4*k + 2, 0, word_of(14'h100 + 14'(k)), 0);
            push_dn(c + 4*k + 4, 1, word_of(14'h0C0 + 14'(k)), 0);
        end
        fork
            begin
                for (int k = 0; k < 4; k++) if_run(32'h400 + 32'(4*k));
                if_req = 1'b0;
            end
            begin
                for (int k = 0; k < 4; k++) dm_run(32'h300 + 32'(4*k), 4'b0000, 32'h0);
                dm_req = 1'b0;
            end
        join

        // Reset while a store waits with cnt==1: its done pulse must never appear
        c = cyc;
        push_iss(c, 14'h004, 4'b1111, 32'h1122_3344, 1);
        dm_req = 1'b1; dm_addr = 32'h10; dm_w_en = 4'b1111; dm_wdata = 32'h1122_3344;
        @(posedge clk); #1;
        rst = 1'b1; dm_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_rst");
        @(posedge clk); #1;
        c = cyc;
        push_iss(c, 14'h200, 4'h0, 32'h0, 0);     push_dn(c + 2, 0, word_of(14'h200), 0);
        push_iss(c + 2, 14'h240, 4'h0, 32'h0, 0); push_dn(c + 4, 1, word_of(14'h240), 0);
        fork
            begin if_run(32'h800); if_req = 1'b0; end
            begin dm_run(32'h900, 4'b0000, 32'h0); dm_req = 1'b0; end
        join

        repeat (5) @(posedge clk);
        #1;
        check("issue_queue_drained", 32'(iss_q.size()), 32'd0);
        check("done_queue_drained", 32'(dn_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
